// File: rtl/anim_pkg.sv
// Shared types and constants for the animated sprite drawing stages.
package anim_pkg;

    typedef logic [10:0] coord_t;
    typedef logic [11:0] rgb_t;

    typedef enum logic [1:0] {StIdle, StReveal, StDone} reveal_state_e;

    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned VER_PIXELS = 768;
    localparam int unsigned HOR_TOTAL  = 1344;
    localparam int unsigned VER_TOTAL  = 806;

    typedef struct packed {
        coord_t vcount;
        logic   vsync;
        logic   vblnk;
        coord_t hcount;
        logic   hsync;
        logic   hblnk;
        rgb_t   rgb;
    } vga_bus_t;

    // 12-bit compare so origin + len never wraps past the 11-bit coordinate range.
    function automatic logic in_span(coord_t pos, coord_t origin, int unsigned len);
        logic [11:0] p;
        logic [11:0] lo;
        logic [11:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, origin};
        hi = lo + 12'(len);
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in_mp  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out_mp (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/anim_reveal_fsm.sv
// Frame-counted reveal sequencer: one more sprite instance every FRAMES_PER_STEP frames.
module anim_reveal_fsm
    import anim_pkg::*;
#(
    parameter int unsigned NUM_OBJ         = 8,
    parameter int unsigned FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_game,
    input  coord_t     hcount,
    input  coord_t     vcount,
    output logic [4:0] revealed,
    output logic       done
);

    localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    reveal_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0] rev_q, rev_d;
    logic tick;

    assign tick = (hcount == '0) && (vcount == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                rev_d = '0;
                if (start_game) state_d = StReveal;
            end
            StReveal: begin
                if (tick) begin
                    if (cnt_q == CntW'(FRAMES_PER_STEP - 1)) begin
                        cnt_d = '0;
                        rev_d = rev_q + 5'd1;
                        if (rev_q == 5'(NUM_OBJ - 1)) state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                cnt_d = '0;
                rev_d = 5'(NUM_OBJ);
            end
            default: state_d = StIdle;
        endcase
        // Dropping the enable aborts from any state.
        if (!start_game) begin
            state_d = StIdle;
            cnt_d   = '0;
            rev_d   = '0;
        end
    end

    assign revealed = rev_q;
    assign done     = (state_q == StDone);

endmodule

// File: rtl/anim_sprite_layer.sv
// Overlays up to NUM_OBJ copies of one ROM sprite on the VGA stream, two-cycle latency.
// Optional horizontal mirroring per instance is built only when SPRITE_MIRROR_EN is defined.
module anim_sprite_layer
    import anim_pkg::*;
#(
    parameter int unsigned NUM_OBJ         = 8,
    parameter int unsigned SPRITE_W        = 64,
    parameter int unsigned SPRITE_H        = 32,
    parameter int unsigned ADDR_W          = 11,
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter logic [11:0] TRANSPARENT_RGB = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_game,
    input  logic [NUM_OBJ*11-1:0] obj_x,
    input  logic [NUM_OBJ*11-1:0] obj_y,
    input  logic [NUM_OBJ-1:0]   obj_mirror,
    input  logic [11:0]          rgb_pixel,
    output logic [ADDR_W-1:0]    pixel_addr,
    output logic [4:0]           revealed,
    output logic                 done,
    vga_if.in_mp                 in,
    vga_if.out_mp                out
);

    if (SPRITE_W * SPRITE_H > 2 ** ADDR_W) begin : g_bad_addr_w
        $error("anim_sprite_layer: SPRITE_W*SPRITE_H exceeds 2**ADDR_W");
    end
    if (NUM_OBJ < 1 || NUM_OBJ > 16) begin : g_bad_num_obj
        $error("anim_sprite_layer: NUM_OBJ must be 1..16");
    end
    if (FRAMES_PER_STEP < 1) begin : g_bad_frames
        $error("anim_sprite_layer: FRAMES_PER_STEP must be >= 1");
    end

    anim_reveal_fsm #(
        .NUM_OBJ        (NUM_OBJ),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_reveal (
        .clk       (clk),
        .rst       (rst),
        .start_game(start_game),
        .hcount    (in.hcount),
        .vcount    (in.vcount),
        .revealed  (revealed),
        .done      (done)
    );

    vga_bus_t in_bus, s1_q, s2_q;
    logic [NUM_OBJ-1:0] obj_hit;
    logic [ADDR_W-1:0]  obj_addr [NUM_OBJ];
    logic               hit, hit_q;
    logic [ADDR_W-1:0]  addr_d, addr_q;

    assign in_bus = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        coord_t x, y, row, col, col_m;
        assign x   = obj_x[11*i +: 11];
        assign y   = obj_y[11*i +: 11];
        assign row = in.vcount - y;
        assign col = in.hcount - x;
`ifdef SPRITE_MIRROR_EN
        assign col_m = obj_mirror[i] ? coord_t'(SPRITE_W - 1) - col : col;
`else
        assign col_m = col;
`endif
        assign obj_addr[i] = ADDR_W'(32'(row) * SPRITE_W + 32'(col_m));
        assign obj_hit[i]  = (5'(i) < revealed) && !in.hblnk && !in.vblnk
                           && in_span(in.hcount, x, SPRITE_W)
                           && in_span(in.vcount, y, SPRITE_H);
    end

`ifndef SPRITE_MIRROR_EN
    logic unused_mirror;
    assign unused_mirror = ^obj_mirror;
`endif

    // Lowest index wins; the address register holds when nothing is hit.
    always_comb begin
        hit    = 1'b0;
        addr_d = addr_q;
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            if (obj_hit[i] && !hit) begin
                hit    = 1'b1;
                addr_d = obj_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            hit_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            s1_q   <= in_bus;
            hit_q  <= hit;
            addr_q <= addr_d;
            s2_q   <= s1_q;
            s2_q.rgb <= (hit_q && (rgb_pixel != TRANSPARENT_RGB)) ? rgb_pixel : s1_q.rgb;
        end
    end

    assign pixel_addr = addr_q;

    assign out.vcount = s2_q.vcount;
    assign out.vsync  = s2_q.vsync;
    assign out.vblnk  = s2_q.vblnk;
    assign out.hcount = s2_q.hcount;
    assign out.hsync  = s2_q.hsync;
    assign out.hblnk  = s2_q.hblnk;
    assign out.rgb    = s2_q.rgb;

endmodule

// File: tb/tb_anim_sprite_layer.sv
// Self-checking bench for anim_sprite_layer with a scoreboard on the two-cycle video path.
module tb_anim_sprite_layer;

    localparam int unsigned NUM_OBJ = 8;
    localparam int unsigned ADDR_W  = 11;

    logic clk = 1'b0;
    logic rst;
    logic start_game;
    logic [NUM_OBJ*11-1:0] obj_x;
    logic [NUM_OBJ*11-1:0] obj_y;
    logic [NUM_OBJ-1:0]    obj_mirror;
    logic [11:0]           rgb_pixel;
    logic [ADDR_W-1:0]     pixel_addr;
    logic [4:0]            revealed;
    logic                  done;
    logic                  rom_ovr_en;
    logic [11:0]           rom_ovr;

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;

    // Asynchronous ROM model: content encodes the address and is never transparent.
    assign rgb_pixel = rom_ovr_en ? rom_ovr : ({1'b0, pixel_addr} ^ 12'h800);

    anim_sprite_layer #(
        .NUM_OBJ        (NUM_OBJ),
        .SPRITE_W       (64),
        .SPRITE_H       (32),
        .ADDR_W         (ADDR_W),
        .FRAMES_PER_STEP(4),
        .TRANSPARENT_RGB(12'h000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_game(start_game),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .obj_mirror(obj_mirror),
        .rgb_pixel (rgb_pixel),
        .pixel_addr(pixel_addr),
        .revealed  (revealed),
        .done      (done),
        .in        (vin),
        .out       (vout)
    );

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] bg;
        logic        ovr_en;
        logic [11:0] ovr;
        logic        chk_addr;
        logic [10:0] exp_addr;
        logic [11:0] exp_rgb;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        logic [25:0] timing;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t pix(input logic [10:0] h, input logic [10:0] v,
                                 input logic [11:0] bg, input logic [11:0] exp_rgb);
        vec_t r;
        r.h = h; r.v = v; r.hb = 1'b0; r.vb = 1'b0; r.bg = bg;
        r.ovr_en = 1'b0; r.ovr = '0; r.chk_addr = 1'b0; r.exp_addr = '0; r.exp_rgb = exp_rgb;
        return r;
    endfunction

    function automatic vec_t row(input logic [10:0] h, input logic [10:0] v, input logic hb,
                                 input logic vb, input logic [11:0] bg, input logic ovr_en,
                                 input logic [11:0] ovr, input logic [10:0] exp_addr,
                                 input logic [11:0] exp_rgb);
        vec_t r;
        r.h = h; r.v = v; r.hb = hb; r.vb = vb; r.bg = bg; r.ovr_en = ovr_en; r.ovr = ovr;
        r.chk_addr = 1'b1; r.exp_addr = exp_addr; r.exp_rgb = exp_rgb;
        return r;
    endfunction

    // One pixel per call; the output two edges later is popped from the scoreboard.
    task automatic drive(input vec_t r);
        exp_t e;
        vin.hcount = r.h;
        vin.vcount = r.v;
        vin.hblnk  = r.hb;
        vin.vblnk  = r.vb;
        vin.hsync  = r.h[3];
        vin.vsync  = r.v[2];
        vin.rgb    = r.bg;
        e.rgb    = r.exp_rgb;
        e.timing = {r.v, r.v[2], r.vb, r.h, r.h[3], r.hb};
        sb.push_back(e);
        @(posedge clk);
        #1;
        rom_ovr_en = r.ovr_en;
        rom_ovr    = r.ovr;
        if (r.chk_addr) check("pixel_addr", 32'(pixel_addr), 32'(r.exp_addr));
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check("out.rgb", 32'(vout.rgb), 32'(e.rgb));
            check("out.timing", 32'({vout.vcount, vout.vsync, vout.vblnk, vout.hcount,
                                     vout.hsync, vout.hblnk}), 32'(e.timing));
        end
    endtask

    task automatic run_frames(input int n, input int mid);
        for (int f = 0; f < n; f++) begin
            drive(pix(11'd0, 11'd0, 12'h0D0, 12'h0D0));
            for (int k = 0; k < mid; k++) drive(pix(11'd900, 11'(700 + k), 12'h0E0, 12'h0E0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_rev;
        logic [10:0] xs [NUM_OBJ];
        logic [10:0] ys [NUM_OBJ];
        xs = '{11'd100, 11'd100, 11'd360, 11'd400, 11'd520, 11'd600, 11'd680, 11'd2000};
        ys = '{11'd200, 11'd200, 11'd400, 11'd410, 11'd400, 11'd400, 11'd400, 11'd400};
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            obj_x[11*i +: 11] = xs[i];
            obj_y[11*i +: 11] = ys[i];
        end
        obj_mirror = '0;
        rom_ovr_en = 1'b0;
        rom_ovr    = '0;

        //      h      v      hb    vb    bg       ovr   ovr_val  addr    rgb
        tbl[0]  = row(11'd110, 11'd205, 1'b0, 1'b0, 12'h123, 1'b1, 12'h0F0, 11'd330, 12'h0F0);
        tbl[1]  = row(11'd110, 11'd205, 1'b0, 1'b0, 12'h456, 1'b1, 12'h000, 11'd330, 12'h456);
        tbl[2]  = row(11'd100, 11'd200, 1'b0, 1'b0, 12'h111, 1'b1, 12'hF00, 11'd0, 12'hF00);
        tbl[3]  = row(11'd163, 11'd231, 1'b0, 1'b0, 12'h222, 1'b0, 12'h000, 11'd2047, 12'hFFF);
        tbl[4]  = row(11'd164, 11'd231, 1'b0, 1'b0, 12'h333, 1'b0, 12'h000, 11'd2047, 12'h333);
        tbl[5]  = row(11'd163, 11'd232, 1'b0, 1'b0, 12'h444, 1'b0, 12'h000, 11'd2047, 12'h444);
        tbl[6]  = row(11'd99, 11'd200, 1'b0, 1'b0, 12'h555, 1'b0, 12'h000, 11'd2047, 12'h555);
        tbl[7]  = row(11'd120, 11'd210, 1'b1, 1'b0, 12'h666, 1'b0, 12'h000, 11'd2047, 12'h666);
        tbl[8]  = row(11'd120, 11'd210, 1'b0, 1'b1, 12'h667, 1'b0, 12'h000, 11'd2047, 12'h667);
        tbl[9]  = row(11'd2040, 11'd401, 1'b0, 1'b0, 12'h777, 1'b0, 12'h000, 11'd104, 12'h868);
        tbl[10] = row(11'd5, 11'd401, 1'b0, 1'b0, 12'h888, 1'b0, 12'h000, 11'd104, 12'h888);
        tbl[11] = row(11'd370, 11'd402, 1'b0, 1'b0, 12'h999, 1'b0, 12'h000, 11'd138, 12'h88A);
        tbl[12] = row(11'd410, 11'd415, 1'b0, 1'b0, 12'hAAA, 1'b0, 12'h000, 11'd1010, 12'hBF2);
        tbl[13] = row(11'd1023, 11'd767, 1'b0, 1'b0, 12'hABC, 1'b0, 12'h000, 11'd1010, 12'hABC);
        tbl[14] = row(11'd2047, 11'd430, 1'b0, 1'b0, 12'hBCD, 1'b0, 12'h000, 11'd1967, 12'hFAF);

        // Reset with a bright background: outputs must stay dark.
        rst = 1'b1;
        start_game = 1'b0;
        vin.hcount = 11'd5; vin.vcount = 11'd5; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        vin.hsync = 1'b1; vin.vsync = 1'b1; vin.rgb = 12'hFFF;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("reset out.rgb", 32'(vout.rgb), 32'h0);
            check("reset out.hcount", 32'(vout.hcount), 32'h0);
            check("reset revealed", 32'(revealed), 32'h0);
            check("reset done", 32'(done), 32'h0);
            check("reset pixel_addr", 32'(pixel_addr), 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(pix(11'(50 + k), 11'd600, 12'(12'hFFF - k), 12'(12'hFFF - k)));
        check("idle revealed", 32'(revealed), 32'h0);

        // Reveal schedule: one step every 4 frame ticks, stable within a frame.
        start_game = 1'b1;
        drive(pix(11'd900, 11'd700, 12'h001, 12'h001));
        for (int t = 1; t <= 36; t++) begin
            exp_rev = (t / 4 > 8) ? 8 : t / 4;
            drive(pix(11'd0, 11'd0, 12'(t), 12'(t)));
            check("revealed@tick", 32'(revealed), 32'(exp_rev));
            check("done@tick", 32'(done), 32'(t >= 32));
            for (int k = 0; k < 3; k++) drive(pix(11'd900, 11'(700 + k), 12'h0C0, 12'h0C0));
            check("revealed@midframe", 32'(revealed), 32'(exp_rev));
        end

        // Datapath vectors with every instance visible.
        for (int i = 0; i < 15; i++) drive(tbl[i]);

        // Abort: the pixel in flight still sees the old count, the next one does not.
        start_game = 1'b0;
        drive(pix(11'd110, 11'd205, 12'h0AA, 12'h94A));
        check("abort revealed", 32'(revealed), 32'h0);
        check("abort done", 32'(done), 32'h0);
        drive(pix(11'd110, 11'd205, 12'h0BB, 12'h0BB));

        // Partial reveal: only instances below the count are drawn.
        start_game = 1'b1;
        drive(pix(11'd900, 11'd700, 12'h002, 12'h002));
        run_frames(12, 2);
        check("partial revealed", 32'(revealed), 32'd3);
        check("partial done", 32'(done), 32'h0);
        drive(pix(11'd370, 11'd402, 12'h010, 12'h88A));
        drive(pix(11'd450, 11'd420, 12'h020, 12'h020));

        // Abort at revealed=3, the next frame shows background in the sprite area.
        start_game = 1'b0;
        drive(pix(11'd900, 11'd700, 12'h003, 12'h003));
        check("abort3 revealed", 32'(revealed), 32'h0);
        run_frames(1, 1);
        drive(pix(11'd110, 11'd205, 12'h030, 12'h030));

        // Restart counts from zero again.
        start_game = 1'b1;
        drive(pix(11'd900, 11'd700, 12'h004, 12'h004));
        run_frames(3, 1);
        check("restart revealed@3", 32'(revealed), 32'h0);
        run_frames(1, 1);
        check("restart revealed@4", 32'(revealed), 32'd1);

        obj_mirror = 8'b0000_0001;
`ifdef SPRITE_MIRROR_EN
        drive(row(11'd100, 11'd200, 1'b0, 1'b0, 12'h040, 1'b0, 12'h000, 11'd63, 12'h83F));
`else
        drive(row(11'd100, 11'd200, 1'b0, 1'b0, 12'h040, 1'b0, 12'h000, 11'd0, 12'h800));
`endif
        drive(pix(11'd900, 11'd700, 12'h050, 12'h050));
        drive(pix(11'd900, 11'd701, 12'h060, 12'h060));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
